// File: rtl/pru_cmd_arbiter.sv
// Two-port draw-command arbiter: one-packet buffer per requester, atomic A/B issue to the PRU preprocessor.
// Optional PRU_ARB_FIXED_PRIO_EN selects fixed priority (port 0 wins ties) instead of round-robin.
module pru_cmd_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_write,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ack,
  input  logic              req1_write,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ack,
  output logic              pru_write,
  output logic [DATA_W-1:0] pru_data,
  input  logic              pru_busy,
  output logic              owner,
  output logic              pkt_done
);

  typedef enum logic [1:0] {ST_IDLE, ST_SEND_A, ST_SEND_B} state_t;
  typedef enum logic [1:0] {BUF_EMPTY, BUF_HALF, BUF_FULL} buf_t;

  state_t            r_state;
  state_t            w_state_nxt;
  buf_t              r_buf_st [2];
  logic [DATA_W-1:0] r_slot_a [2];
  logic [DATA_W-1:0] r_slot_b [2];
  logic [DATA_W-1:0] w_data   [2];
  logic              r_grant;
  logic              w_grant_nxt;
  logic              w_grant_sel;
  logic [1:0]        w_write;
  logic [1:0]        w_full;
  logic [1:0]        w_ack;

  assign w_write = {req1_write, req0_write};
  assign w_data[0] = req0_data;
  assign w_data[1] = req1_data;

  // Acks are held low while reset is asserted even though the buffers read EMPTY.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_full[i] = (r_buf_st[i] == BUF_FULL);
      w_ack[i]  = rst_n && w_write[i] && !w_full[i];
    end
  end

  assign req0_ack = w_ack[0];
  assign req1_ack = w_ack[1];

`ifdef PRU_ARB_FIXED_PRIO_EN
  assign w_grant_sel = !w_full[0];
`else
  logic r_last_grant;

  always_comb begin
    if (w_full[0] && w_full[1]) w_grant_sel = ~r_last_grant;
    else                        w_grant_sel = !w_full[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_last_grant <= 1'b1;
    else if (pkt_done) r_last_grant <= r_grant;
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    pru_write   = 1'b0;
    pru_data    = '0;
    owner       = 1'b0;
    pkt_done    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|w_full) begin
          w_grant_nxt = w_grant_sel;
          w_state_nxt = ST_SEND_A;
        end
      end
      ST_SEND_A: begin
        pru_write = 1'b1;
        pru_data  = r_slot_a[r_grant];
        owner     = r_grant;
        if (!pru_busy) w_state_nxt = ST_SEND_B;
      end
      ST_SEND_B: begin
        pru_write = 1'b1;
        pru_data  = r_slot_b[r_grant];
        owner     = r_grant;
        if (!pru_busy) begin
          pkt_done    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_grant     <= 1'b0;
      r_buf_st[0] <= BUF_EMPTY;
      r_buf_st[1] <= BUF_EMPTY;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      // A FULL buffer never acks, so drain and fill cannot collide on one port.
      for (int i = 0; i < 2; i++) begin
        if (pkt_done && (r_grant == 1'(i)))
          r_buf_st[i] <= BUF_EMPTY;
        else if (w_ack[i])
          r_buf_st[i] <= (r_buf_st[i] == BUF_EMPTY) ? BUF_HALF : BUF_FULL;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (w_ack[i]) begin
        if (r_buf_st[i] == BUF_EMPTY) r_slot_a[i] <= w_data[i];
        else                          r_slot_b[i] <= w_data[i];
      end
    end
  end

endmodule

// File: tb/tb_pru_cmd_arbiter.sv
// Directed testbench for pru_cmd_arbiter; honours PRU_ARB_FIXED_PRIO_EN for the second tie.
module tb_pru_cmd_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_write, req1_write, pru_busy;
  logic [31:0] req0_data, req1_data;
  logic        req0_ack, req1_ack, pru_write, owner, pkt_done;
  logic [31:0] pru_data;
  logic        f;
  logic [31:0] pa [2];
  logic [31:0] pb [2];

  int checks = 0;
  int errors = 0;

  pru_cmd_arbiter #(.DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_write(req0_write), .req0_data(req0_data), .req0_ack(req0_ack),
    .req1_write(req1_write), .req1_data(req1_data), .req1_ack(req1_ack),
    .pru_write(pru_write), .pru_data(pru_data), .pru_busy(pru_busy),
    .owner(owner), .pkt_done(pkt_done)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic w0, input logic [31:0] d0, input logic w1,
                     input logic [31:0] d1, input logic b);
    req0_write = w0; req0_data = d0;
    req1_write = w1; req1_data = d1;
    pru_busy   = b;
    #1;
  endtask

  task automatic out(input string tag, input logic w, input logic [31:0] d,
                     input logic o, input logic pd);
    chk({tag, ".write"}, 32'(pru_write), 32'(w));
    chk({tag, ".data"},  pru_data,        d);
    chk({tag, ".owner"}, 32'(owner),      32'(o));
    chk({tag, ".done"},  32'(pkt_done),   32'(pd));
  endtask

  task automatic acks(input string tag, input logic a0, input logic a1);
    chk({tag, ".ack0"}, 32'(req0_ack), 32'(a0));
    chk({tag, ".ack1"}, 32'(req1_ack), 32'(a1));
  endtask

  initial begin
    // Reset with writes asserted and random data/busy
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drv(1'b1, $urandom, 1'b1, $urandom, 1'($urandom_range(0, 1)));
      out("rst", 1'b0, 32'h0, 1'b0, 1'b0);
      acks("rst", 1'b0, 1'b0);
      tick;
    end
    drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    rst_n = 1'b1;
    tick;

    // Tie straight after reset: port 0 first, one IDLE cycle, then port 1
    drv(1'b1, 32'hA000_0000, 1'b1, 32'hA111_1111, 1'b0); acks("tie.w1", 1'b1, 1'b1); tick;
    drv(1'b1, 32'hB000_0000, 1'b1, 32'hB111_1111, 1'b0); acks("tie.w2", 1'b1, 1'b1); tick;
    drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0); out("tie.idle", 1'b0, 32'h0, 1'b0, 1'b0); tick;
    out("tie.a0",  1'b1, 32'hA000_0000, 1'b0, 1'b0); tick;
    out("tie.b0",  1'b1, 32'hB000_0000, 1'b0, 1'b1); tick;
    out("tie.gap", 1'b0, 32'h0,         1'b0, 1'b0); tick;
    out("tie.a1",  1'b1, 32'hA111_1111, 1'b1, 1'b0); tick;
    out("tie.b1",  1'b1, 32'hB111_1111, 1'b1, 1'b1); tick;
    out("tie.end", 1'b0, 32'h0,         1'b0, 1'b0); tick;

    // Single packet on port 0 (leaves last grant at 0)
    drv(1'b1, 32'h0012_3456, 1'b0, 32'h0, 1'b0); acks("sp.w1", 1'b1, 1'b0); tick;
    drv(1'b1, 32'h0000_0A0F, 1'b0, 32'h0, 1'b0); acks("sp.w2", 1'b1, 1'b0); tick;
    drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0); out("sp.idle", 1'b0, 32'h0, 1'b0, 1'b0); tick;
    out("sp.a",   1'b1, 32'h0012_3456, 1'b0, 1'b0); tick;
    out("sp.b",   1'b1, 32'h0000_0A0F, 1'b0, 1'b1); tick;
    out("sp.end", 1'b0, 32'h0,         1'b0, 1'b0); tick;

    // Second tie: round-robin favours port 1 now, fixed priority keeps port 0
`ifdef PRU_ARB_FIXED_PRIO_EN
    f = 1'b0;
`else
    f = 1'b1;
`endif
    pa[0] = 32'hC0C0_0001; pb[0] = 32'hD0D0_0002;
    pa[1] = 32'hC1C1_0003; pb[1] = 32'hD1D1_0004;
    drv(1'b1, pa[0], 1'b1, pa[1], 1'b0); acks("tie2.w1", 1'b1, 1'b1); tick;
    drv(1'b1, pb[0], 1'b1, pb[1], 1'b0); acks("tie2.w2", 1'b1, 1'b1); tick;
    drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0); out("tie2.idle", 1'b0, 32'h0, 1'b0, 1'b0); tick;
    out("tie2.a_first",  1'b1, pa[f],  f,  1'b0); tick;
    out("tie2.b_first",  1'b1, pb[f],  f,  1'b1); tick;
    out("tie2.gap",      1'b0, 32'h0, 1'b0, 1'b0); tick;
    out("tie2.a_second", 1'b1, pa[~f], ~f, 1'b0); tick;
    out("tie2.b_second", 1'b1, pb[~f], ~f, 1'b1); tick;
    out("tie2.end",      1'b0, 32'h0, 1'b0, 1'b0); tick;

    // Stall: 5 busy cycles in SEND_A, 3 in SEND_B
    drv(1'b1, 32'hE1E1_E1E1, 1'b0, 32'h0, 1'b0); tick;
    drv(1'b1, 32'hF2F2_F2F2, 1'b0, 32'h0, 1'b0); tick;
    drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b1); out("st.idle", 1'b0, 32'h0, 1'b0, 1'b0); tick;
    for (int i = 0; i < 5; i++) begin
      out("st.a_hold", 1'b1, 32'hE1E1_E1E1, 1'b0, 1'b0); tick;
    end
    drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0); out("st.a_go", 1'b1, 32'hE1E1_E1E1, 1'b0, 1'b0); tick;
    drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      out("st.b_hold", 1'b1, 32'hF2F2_F2F2, 1'b0, 1'b0); tick;
    end
    drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0); out("st.b_go", 1'b1, 32'hF2F2_F2F2, 1'b0, 1'b1); tick;
    out("st.end", 1'b0, 32'h0, 1'b0, 1'b0); tick;

    // Port 1 holds a third word while FULL; accepted the cycle after pkt_done
    drv(1'b0, 32'h0, 1'b1, 32'h6666_0001, 1'b0); acks("fb.w1", 1'b0, 1'b1); tick;
    drv(1'b0, 32'h0, 1'b1, 32'h6666_0002, 1'b0); acks("fb.w2", 1'b0, 1'b1); tick;
    drv(1'b0, 32'h0, 1'b1, 32'h6666_0003, 1'b0);
    acks("fb.idle", 1'b0, 1'b0); out("fb.idle", 1'b0, 32'h0, 1'b0, 1'b0); tick;
    acks("fb.sa", 1'b0, 1'b0); out("fb.sa", 1'b1, 32'h6666_0001, 1'b1, 1'b0); tick;
    acks("fb.sb", 1'b0, 1'b0); out("fb.sb", 1'b1, 32'h6666_0002, 1'b1, 1'b1); tick;
    acks("fb.after", 1'b0, 1'b1); out("fb.after", 1'b0, 32'h0, 1'b0, 1'b0); tick;
    drv(1'b0, 32'h0, 1'b1, 32'h6666_0004, 1'b0); acks("fb.w4", 1'b0, 1'b1); tick;
    drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0); out("fb.idle2", 1'b0, 32'h0, 1'b0, 1'b0); tick;
    out("fb.a2", 1'b1, 32'h6666_0003, 1'b1, 1'b0); tick;
    out("fb.b2", 1'b1, 32'h6666_0004, 1'b1, 1'b1); tick;
    out("fb.end", 1'b0, 32'h0, 1'b0, 1'b0); tick;

    // Mid-packet reset: port 0 in SEND_B, port 1 HALF; everything must be discarded
    drv(1'b1, 32'h7777_0001, 1'b1, 32'h9999_0001, 1'b0); acks("mr.w1", 1'b1, 1'b1); tick;
    drv(1'b1, 32'h7777_0002, 1'b0, 32'h0, 1'b0); acks("mr.w2", 1'b1, 1'b0); tick;
    drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0); out("mr.idle", 1'b0, 32'h0, 1'b0, 1'b0); tick;
    out("mr.a", 1'b1, 32'h7777_0001, 1'b0, 1'b0); tick;
    drv(1'b0, 32'h0, 1'b1, 32'h9999_0002, 1'b1); out("mr.b", 1'b1, 32'h7777_0002, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    out("mr.in_rst", 1'b0, 32'h0, 1'b0, 1'b0); acks("mr.in_rst", 1'b0, 1'b0);
    tick;
    drv(1'b0, 32'h0, 1'b1, 32'h9999_0002, 1'b0);
    out("mr.held", 1'b0, 32'h0, 1'b0, 1'b0); acks("mr.held", 1'b0, 1'b0);
    drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    rst_n = 1'b1;
    tick;
    drv(1'b0, 32'h0, 1'b1, 32'h5151_0001, 1'b0); acks("mr.p1w1", 1'b0, 1'b1); tick;
    drv(1'b0, 32'h0, 1'b1, 32'h5151_0002, 1'b0); acks("mr.p1w2", 1'b0, 1'b1); tick;
    drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0); out("mr.p1idle", 1'b0, 32'h0, 1'b0, 1'b0); tick;
    out("mr.p1a", 1'b1, 32'h5151_0001, 1'b1, 1'b0); tick;
    out("mr.p1b", 1'b1, 32'h5151_0002, 1'b1, 1'b1); tick;
    out("mr.end", 1'b0, 32'h0, 1'b0, 1'b0); tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
